// File: rtl/data_memory_dump_reader.sv
// Read-side dump engine for DataMemory: after processDone it sweeps an address window
// through the memory read port and streams each (address, word) pair on a valid/ready port.
module data_memory_dump_reader #(
    parameter int WIDTH      = 36,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int START_ADDR = 0,
    parameter int WORD_COUNT = DEPTH
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    output logic                  memReq,
    output logic                  memWriteEn,
    output logic [ADDR_WIDTH-1:0] memAddress,
    input  logic [WIDTH-1:0]      memDataOut,
    output logic [WIDTH-1:0]      outData,
    output logic [ADDR_WIDTH-1:0] outAddr,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  busy,
    output logic                  done
);

    generate
        if (WORD_COUNT < 1 || WORD_COUNT > DEPTH) begin : g_bad_word_count
            $error("data_memory_dump_reader: WORD_COUNT must lie in 1..DEPTH");
        end
        if (START_ADDR < 0 || START_ADDR >= DEPTH) begin : g_bad_start_addr
            $error("data_memory_dump_reader: START_ADDR must lie in 0..DEPTH-1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_COUNT = ADDR_WIDTH'(WORD_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_r, state_next_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_next_s;
    logic [ADDR_WIDTH-1:0] count_r, count_next_s;
    logic [WIDTH-1:0]      out_data_r, out_data_next_s;
    logic [ADDR_WIDTH-1:0] out_addr_r, out_addr_next_s;
    logic                  out_valid_r, out_valid_next_s;
    logic                  mem_req_r, mem_req_next_s;
    logic [ADDR_WIDTH-1:0] mem_address_r, mem_address_next_s;
    logic                  busy_r, busy_next_s;
    logic                  done_r, done_next_s;

    // Next-state and datapath update; the sweep ends on the word count, never on the address
    always_comb begin
        state_next_s     = state_r;
        addr_next_s      = addr_r;
        count_next_s     = count_r;
        out_data_next_s  = out_data_r;
        out_addr_next_s  = out_addr_r;
        out_valid_next_s = out_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    addr_next_s  = FIRST_ADDR;
                    count_next_s = ADDR_ZERO;
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                out_data_next_s  = memDataOut;
                out_addr_next_s  = addr_r;
                out_valid_next_s = 1'b1;
                state_next_s     = ST_SEND;
            end
            ST_SEND: begin
                if (out_valid_r && outReady) begin
                    out_valid_next_s = 1'b0;
                    if (count_r == LAST_COUNT) begin
                        state_next_s = ST_DONE;
                    end else begin
                        addr_next_s  = (addr_r == TOP_ADDR) ? ADDR_ZERO : addr_r + ADDR_ONE;
                        count_next_s = count_r + ADDR_ONE;
                        state_next_s = ST_READ;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s     = ST_IDLE;
                out_valid_next_s = 1'b0;
            end
        endcase
    end

    // Port-side outputs are decoded from the next state so they can be registered
    always_comb begin
        mem_req_next_s     = (state_next_s == ST_READ) || (state_next_s == ST_WAIT);
        mem_address_next_s = mem_req_next_s ? addr_next_s : ADDR_ZERO;
        busy_next_s        = (state_next_s != ST_IDLE);
        done_next_s        = (state_next_s == ST_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_r       <= ST_IDLE;
            addr_r        <= ADDR_ZERO;
            count_r       <= ADDR_ZERO;
            out_data_r    <= {WIDTH{1'b0}};
            out_addr_r    <= ADDR_ZERO;
            out_valid_r   <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_address_r <= ADDR_ZERO;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            addr_r        <= addr_next_s;
            count_r       <= count_next_s;
            out_data_r    <= out_data_next_s;
            out_addr_r    <= out_addr_next_s;
            out_valid_r   <= out_valid_next_s;
            mem_req_r     <= mem_req_next_s;
            mem_address_r <= mem_address_next_s;
            busy_r        <= busy_next_s;
            done_r        <= done_next_s;
        end
    end

    assign memWriteEn = 1'b0;
    assign memReq     = mem_req_r;
    assign memAddress = mem_address_r;
    assign outData    = out_data_r;
    assign outAddr    = out_addr_r;
    assign outValid   = out_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: doc/data_memory_dump_reader.md
# data_memory_dump_reader

Read-side companion to `DataMemory`: once the cores signal completion (`processDone`), this block takes ownership of the memory's read port. It sweeps a configurable address window, reading one word at a time. Each word is presented, with its address, on a valid/ready output stream for the result-dump / checker logic. It sits between `DataMemory` and the post-run dump path, muxed onto the memory port by `memReq`.

## Interface

Parameters:
- `WIDTH`, 36: memory word width in bits.
- `DEPTH`, 2048: memory depth in words.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: address width.
- `START_ADDR`, 0: first address read.
- `WORD_COUNT`, `DEPTH`: number of words per sweep.
  - Legal range is 1..`DEPTH`.
  - An out-of-range value is an elaboration error.

Ports:
- `clock`  in  1: single clock, all state updates on its rising edge.
- `resetN`  in  1: synchronous, active-low reset.
- `start`  in  1: sweep request, level-sampled in IDLE only. Connected to `processDone`.
- `memReq`  out  1: high while the block drives the memory port (READ and WAIT states).
- `memWriteEn`  out  1: constant 0. The block never writes.
- `memAddress`  out  `ADDR_WIDTH`: read address to `DataMemory`.
- `memDataOut`  in  `WIDTH`: `DataMemory.dataOut`.
- `outData`  out  `WIDTH`: captured word.
- `outAddr`  out  `ADDR_WIDTH`: address `outData` was read from.
- `outValid`  out  1: stream valid.
- `outReady`  in  1: stream ready from the consumer.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse after the last word is accepted.

## Operation

- FSM states: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - If `start`=1 at an edge: `addr`<=`START_ADDR`, `count`<=0, go to READ.
  - Otherwise stay in IDLE.
- READ: `memAddress`=`addr`, `memReq`=1. Next edge goes to WAIT.
  - `DataMemory` samples the address at this edge, so `dataOut` is valid throughout WAIT.
- WAIT: `memReq`=1, `memAddress`=`addr`. At the edge:
  - `outData`<=`memDataOut`
  - `outAddr`<=`addr`
  - `outValid`<=1
  - go to SEND.
- SEND: hold `outData`/`outAddr`/`outValid` stable until `outValid`&`outReady` is seen at an edge. At that edge:
  - `outValid`<=0.
  - If `count`==`WORD_COUNT`-1: go to DONE.
  - Otherwise: `addr`<=`addr`+1 modulo `DEPTH`, `count`<=`count`+1, go to READ.
- DONE: `done`=1 for exactly this cycle. Next edge goes to IDLE.
- `start` is ignored outside IDLE.
  - If `start` is still high when IDLE is re-entered, a new sweep begins on the next edge. This is legal; the consumer is expected to drop `processDone`.
- Address wrap: when `START_ADDR`+`WORD_COUNT` > `DEPTH`, the address rolls over from `DEPTH`-1 to 0. `count`, not `addr`, terminates the sweep.
- `memAddress` is 0 whenever `memReq`=0.
- `memWriteEn` is 0 in all states, including during reset.

## Timing

- Reset: any edge with `resetN`=0 forces the following values, regardless of current state (including mid-sweep):
  - state=IDLE
  - `addr`=0, `count`=0
  - `outData`=0, `outAddr`=0, `outValid`=0
  - `done`=0, `busy`=0, `memReq`=0
- A partially sent word is dropped on reset, not completed.
- Start latency: `start` sampled at edge E0 → READ during cycle E0..E1 → `outValid` rises at edge E2.
- Per-word cost: 3 cycles minimum (READ, WAIT, SEND with `outReady`=1). Each extra cycle of `outReady`=0 adds one cycle.
- Full sweep with `outReady` tied high:
  - `done` pulses 3×`WORD_COUNT`+1 cycles after the start edge.
  - `busy` stays high for 3×`WORD_COUNT`+1 cycles.
- Stream rules:
  - `outValid` never drops without a handshake.
  - `outData`/`outAddr` never change while `outValid`=1.
  - `outReady` may be high before `outValid`. The handshake then completes at the first SEND edge.
- `done` and `outValid` are never high in the same cycle.

## Test plan

- Basic sweep: preload `DataMemory`[0..3]=`36'hABC`, `36'h123`, `36'h0`, `36'hFFFFFFFFF`; set `WORD_COUNT`=4; pulse `start`; hold `outReady`=1.
  - Required: (addr,data) pairs (0,ABC), (1,123), (2,0), (3,FFFFFFFFF) in order.
  - Required: `done` on cycle 13 after the start edge; `memWriteEn`=0 throughout.
- Backpressure: same as the basic sweep, but `outReady`=0 for 5 cycles on word 1.
  - Required: `outData`=123 and `outAddr`=1 held stable for all 5 cycles.
  - Required: no skipped or duplicated words; `done` 5 cycles later (cycle 18).
- Wrap-around: `START_ADDR`=2046, `WORD_COUNT`=4.
  - Required: `outAddr` sequence 2046, 2047, 0, 1, then `done`.
- Reset mid-sweep: drive `resetN`=0 for one edge while in SEND of word 2.
  - Required: `outValid`=0, `busy`=0, `memReq`=0 the next cycle; no `done` pulse.
  - Required: a new `start` restarts from `START_ADDR`.
- Start handling: hold `start`=1 continuously.
  - Required: toggling `start` during a sweep has no effect.
  - Required: after `done`, exactly one IDLE cycle, then a second sweep begins with `outAddr`=`START_ADDR`.
